// File: rtl/switch_debouncer.sv
// Switch conditioner: two-flop synchroniser, debounce FSM, stable level, edge pulses, press toggle.
// Define AUTO_REPEAT_EN to add timed repeat rise pulses while the switch is held high.
module switch_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned REPEAT_DELAY    = 50_000_000,
    parameter int unsigned REPEAT_PERIOD   = 20_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic switch,
    output logic switch_level,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic toggle_state
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
        $error("switch_debouncer: illegal parameter value");
    end

    typedef enum logic [1:0] {StLow, StWaitH, StHigh, StWaitL} state_e;

    state_e          state;
    logic            sync1;
    logic            sync2;
    logic [CntW-1:0] cnt;

`ifdef AUTO_REPEAT_EN
    localparam int unsigned RptMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RptW   = $clog2(RptMax + 1);
    localparam logic [RptW-1:0] RptDelay  = RptW'(REPEAT_DELAY);
    localparam logic [RptW-1:0] RptPeriod = RptW'(REPEAT_PERIOD);

    logic [RptW-1:0] rpt_cnt;
    logic            rpt_first;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1        <= 1'b0;
            sync2        <= 1'b0;
            state        <= StLow;
            cnt          <= '0;
            switch_level <= 1'b0;
            rise_pulse   <= 1'b0;
            fall_pulse   <= 1'b0;
            toggle_state <= 1'b0;
`ifdef AUTO_REPEAT_EN
            rpt_cnt      <= '0;
            rpt_first    <= 1'b1;
`endif
        end else begin
            sync1      <= switch;
            sync2      <= sync1;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            case (state)
                StLow: begin
                    if (sync2) begin
                        state <= StWaitH;
                        cnt   <= '0;
                    end
                end
                StWaitH: begin
                    if (!sync2) begin
                        state <= StLow;
                        cnt   <= '0;
                    end else if (cnt == CntMax) begin
                        state        <= StHigh;
                        cnt          <= '0;
                        switch_level <= 1'b1;
                        rise_pulse   <= 1'b1;
                        toggle_state <= ~toggle_state;
`ifdef AUTO_REPEAT_EN
                        // Counts edges since the accepted rise, so the delay lands on t0+DELAY.
                        rpt_cnt      <= RptW'(1);
                        rpt_first    <= 1'b1;
`endif
                    end else begin
                        cnt <= cnt + CntW'(1);
                    end
                end
                StHigh: begin
                    if (!sync2) begin
                        state <= StWaitL;
                        cnt   <= '0;
`ifdef AUTO_REPEAT_EN
                        rpt_cnt   <= '0;
                        rpt_first <= 1'b1;
`endif
                    end
`ifdef AUTO_REPEAT_EN
                    else if (rpt_cnt == (rpt_first ? RptDelay : RptPeriod)) begin
                        rise_pulse <= 1'b1;
                        rpt_cnt    <= RptW'(1);
                        rpt_first  <= 1'b0;
                    end else begin
                        rpt_cnt <= rpt_cnt + RptW'(1);
                    end
`endif
                end
                StWaitL: begin
                    if (sync2) begin
                        state <= StHigh;
                        cnt   <= '0;
                    end else if (cnt == CntMax) begin
                        state        <= StLow;
                        cnt          <= '0;
                        switch_level <= 1'b0;
                        fall_pulse   <= 1'b1;
                    end else begin
                        cnt <= cnt + CntW'(1);
                    end
                end
                default: state <= StLow;
            endcase
        end
    end

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer: expected pulses are queued at stimulus time and
// matched against observed pulses by a negedge monitor.
module tb_switch_debouncer;

    localparam int unsigned DEB  = 8;
    localparam int unsigned RDLY = 20;
    localparam int unsigned RPER = 10;
    // Drive just after edge k: sync1 at k+1, sync2 at k+2, FSM wait entry k+3, accept k+3+DEB.
    localparam int LAT = DEB + 3;

    logic clk = 1'b0;
    logic rst;
    logic switch;
    logic switch_level;
    logic rise_pulse;
    logic fall_pulse;
    logic toggle_state;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit m_toggle = 1'b0;
    int t0;

    typedef struct {
        int cyc;
        bit rise;
        bit fall;
        bit tog;
        bit lvl;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;

    switch_debouncer #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (RDLY),
        .REPEAT_PERIOD  (RPER)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .switch      (switch),
        .switch_level(switch_level),
        .rise_pulse  (rise_pulse),
        .fall_pulse  (fall_pulse),
        .toggle_state(toggle_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_ev(input int c, input bit r, input bit f, input bit tg, input bit lv);
        ev_t e;
        e.cyc  = c;
        e.rise = r;
        e.fall = f;
        e.tog  = tg;
        e.lvl  = lv;
        exp_q.push_back(e);
    endtask

    task automatic expect_press(input int at);
        m_toggle = ~m_toggle;
        push_ev(at, 1'b1, 1'b0, m_toggle, 1'b1);
    endtask

    task automatic expect_release(input int at);
        push_ev(at, 1'b0, 1'b1, m_toggle, 1'b0);
    endtask

    always @(negedge clk) begin
        if (rise_pulse || fall_pulse) begin
            check("pulse_exclusive", int'(rise_pulse & fall_pulse), 0);
            if (exp_q.size() == 0) begin
                check("unexpected_pulse_at_cycle", cyc, -1);
            end else begin
                mon_e = exp_q.pop_front();
                check("pulse_cycle", cyc, mon_e.cyc);
                check("pulse_kind", int'({rise_pulse, fall_pulse}),
                      int'({mon_e.rise, mon_e.fall}));
                check("pulse_toggle", int'(toggle_state), int'(mon_e.tog));
                check("pulse_level", int'(switch_level), int'(mon_e.lvl));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: run did not complete within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        // Switch already high while in reset
        rst    = 1'b1;
        switch = 1'b1;
        tick(3);
        check("rst_level", int'(switch_level), 0);
        check("rst_rise", int'(rise_pulse), 0);
        check("rst_fall", int'(fall_pulse), 0);
        check("rst_toggle", int'(toggle_state), 0);

        rst = 1'b0;
        expect_press(cyc + LAT);
        tick(LAT);
        check("t1_level", int'(switch_level), 1);
        check("t1_toggle", int'(toggle_state), int'(m_toggle));
        switch = 1'b0;
        expect_release(cyc + LAT);
        tick(LAT + 4);
        check("t1_level_low", int'(switch_level), 0);

        // Bouncy press: only the final steady high is accepted
        switch = 1'b1;
        tick(5);
        switch = 1'b0;
        tick(3);
        switch = 1'b1;
        expect_press(cyc + LAT);
        tick(LAT);
        check("t2_level", int'(switch_level), 1);
        check("t2_toggle", int'(toggle_state), int'(m_toggle));

        // 7-cycle low glitch rejected, then a real release
        switch = 1'b0;
        tick(7);
        switch = 1'b1;
        tick(12);
        check("t3_glitch_level", int'(switch_level), 1);
        switch = 1'b0;
        expect_release(cyc + LAT);
        tick(LAT + 4);
        check("t3_level", int'(switch_level), 0);
        check("t3_toggle", int'(toggle_state), int'(m_toggle));

        // Three clean presses
        for (int i = 0; i < 3; i++) begin
            switch = 1'b1;
            expect_press(cyc + LAT);
            tick(20);
            check("t4_toggle", int'(toggle_state), int'(m_toggle));
            switch = 1'b0;
            expect_release(cyc + LAT);
            tick(20);
            check("t4_level", int'(switch_level), 0);
        end

        // Reset while waiting with cnt==5
        switch = 1'b1;
        tick(8);
        rst = 1'b1;
        #1;
        m_toggle = 1'b0;
        check("t5_rst_level", int'(switch_level), 0);
        check("t5_rst_toggle", int'(toggle_state), 0);
        check("t5_rst_rise", int'(rise_pulse), 0);
        tick(3);
        rst = 1'b0;
        expect_press(cyc + LAT);
        tick(LAT);
        check("t5_level", int'(switch_level), 1);
        switch = 1'b0;
        expect_release(cyc + LAT);
        tick(LAT + 4);

        // Long hold: repeat pulses only with AUTO_REPEAT_EN
        switch = 1'b1;
        t0 = cyc + LAT;
        expect_press(t0);
`ifdef AUTO_REPEAT_EN
        for (int n = 0; n < 4; n++) begin
            push_ev(t0 + int'(RDLY) + n * int'(RPER), 1'b1, 1'b0, m_toggle, 1'b1);
        end
`endif
        tick(LAT + 55);
        check("t6_toggle_hold", int'(toggle_state), int'(m_toggle));
        switch = 1'b0;
        expect_release(cyc + LAT);
        tick(LAT + 4);
        check("t6_level", int'(switch_level), 0);
        check("t6_toggle", int'(toggle_state), int'(m_toggle));

        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
